// File: rtl/abs_dif_seq.sv
// rtl/abs_dif_seq.sv - sequential |a-b| engine using an external agb/aeb/alb comparator
module abs_dif_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] cmp_a,
  output logic [N-1:0] cmp_b,
  input  logic         agb,
  input  logic         aeb,
  input  logic         alb,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] dif,
  output logic         a_lt_b,
  output logic         a_eq_b,
  output logic         err
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_SUB,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  cmp_a_q, cmp_a_d;
  logic [N-1:0]  cmp_b_q, cmp_b_d;
  logic [N-1:0]  max_q, max_d;
  logic [N-1:0]  min_q, min_d;
  logic [N-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          borrow_q, borrow_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  dif_q, dif_d;
  logic          a_lt_b_q, a_lt_b_d;
  logic          a_eq_b_q, a_eq_b_d;
  logic          err_q, err_d;
  logic          flags_one_hot;
  logic          diff_bit;

  // Next-state and datapath: latch operands, order them by the comparator flags,
  // then subtract min from max one bit per cycle, LSB first.
  always_comb begin
    state_d       = state_q;
    cmp_a_d       = cmp_a_q;
    cmp_b_d       = cmp_b_q;
    max_d         = max_q;
    min_d         = min_q;
    res_d         = res_q;
    cnt_d         = cnt_q;
    borrow_d      = borrow_q;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    dif_d         = dif_q;
    a_lt_b_d      = a_lt_b_q;
    a_eq_b_d      = a_eq_b_q;
    err_d         = err_q;
    flags_one_hot = (agb & ~aeb & ~alb) | (~agb & aeb & ~alb) | (~agb & ~aeb & alb);
    diff_bit      = max_q[0] ^ min_q[0] ^ borrow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cmp_a_d = a;
          cmp_b_d = b;
          busy_d  = 1'b1;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (!flags_one_hot) begin
          err_d    = 1'b1;
          dif_d    = '0;
          a_lt_b_d = 1'b0;
          a_eq_b_d = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else if (aeb) begin
          err_d    = 1'b0;
          dif_d    = '0;
          a_lt_b_d = 1'b0;
          a_eq_b_d = 1'b1;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          max_d    = agb ? cmp_a_q : cmp_b_q;
          min_d    = agb ? cmp_b_q : cmp_a_q;
          a_lt_b_d = alb;
          a_eq_b_d = 1'b0;
          err_d    = 1'b0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_SUB;
        end
      end
      S_SUB: begin
        borrow_d = (~max_q[0] & min_q[0]) | (~(max_q[0] ^ min_q[0]) & borrow_q);
        max_d    = max_q >> 1;
        min_d    = min_q >> 1;
        res_d    = {diff_bit, res_q[N-1:1]};
        cnt_d    = cnt_q + 1'b1;
        busy_d   = 1'b1;
        if (cnt_q == LAST_BIT) begin
          dif_d   = res_d;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; busy and done are registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cmp_a_q  <= '0;
      cmp_b_q  <= '0;
      max_q    <= '0;
      min_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dif_q    <= '0;
      a_lt_b_q <= 1'b0;
      a_eq_b_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmp_a_q  <= cmp_a_d;
      cmp_b_q  <= cmp_b_d;
      max_q    <= max_d;
      min_q    <= min_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dif_q    <= dif_d;
      a_lt_b_q <= a_lt_b_d;
      a_eq_b_q <= a_eq_b_d;
      err_q    <= err_d;
    end
  end

  assign cmp_a  = cmp_a_q;
  assign cmp_b  = cmp_b_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign dif    = dif_q;
  assign a_lt_b = a_lt_b_q;
  assign a_eq_b = a_eq_b_q;
  assign err    = err_q;

endmodule

// File: tb/tb_abs_dif_seq.sv
// tb/tb_abs_dif_seq.sv - directed self-checking bench for abs_dif_seq
module tb_abs_dif_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b;
  logic [3:0] cmp_a, cmp_b;
  logic       agb, aeb, alb;
  logic       busy, done;
  logic [3:0] dif;
  logic       a_lt_b, a_eq_b, err;
  logic       force_bad;

  int checks   = 0;
  int failures = 0;
  int lat;
  int busy_cnt;
  int done_cnt;

  abs_dif_seq #(.N(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .agb(agb), .aeb(aeb), .alb(alb),
    .busy(busy), .done(done), .dif(dif), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b), .err(err)
  );

  always #5 clk = ~clk;

  // Comparator stub: true compare, or a non-one-hot flag pattern on demand
  always_comb begin
    agb = force_bad ? 1'b1 : (cmp_a > cmp_b);
    aeb = force_bad ? 1'b1 : (cmp_a == cmp_b);
    alb = force_bad ? 1'b0 : (cmp_a < cmp_b);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle start, wait (bounded) for done, check latency, results and single-cycle strobe
  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input int exp_lat, input logic [3:0] exp_dif,
                        input logic exp_lt, input logic exp_eq, input logic exp_err,
                        input int exp_busy);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_dif"}, dif, exp_dif);
    chk({tag, "_a_lt_b"}, a_lt_b, exp_lt);
    chk({tag, "_a_eq_b"}, a_eq_b, exp_eq);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 1'b0);
    chk({tag, "_dif_held"}, dif, exp_dif);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; force_bad = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_outs", {cmp_a, cmp_b, dif, a_lt_b, a_eq_b, err}, 15'd0);
    rst = 1'b0;

    run_op("a9_b3",   4'd9,  4'd3,  6, 4'd6,  1'b0, 1'b0, 1'b0, 5);
    run_op("a2_b13",  4'd2,  4'd13, 6, 4'd11, 1'b1, 1'b0, 1'b0, 5);
    run_op("a15_b0",  4'd15, 4'd0,  6, 4'd15, 1'b0, 1'b0, 1'b0, 5);
    run_op("a7_b7",   4'd7,  4'd7,  2, 4'd0,  1'b0, 1'b1, 1'b0, 1);

    force_bad = 1'b1;
    run_op("bad_flags", 4'd5, 4'd1, 2, 4'd0, 1'b0, 1'b0, 1'b1, 1);
    force_bad = 1'b0;
    run_op("a5_b1",   4'd5,  4'd1,  6, 4'd4,  1'b0, 1'b0, 1'b0, 5);

    // start held high; a changes during SUB; next op accepted right after DONE
    @(negedge clk);
    a = 4'd12; b = 4'd4; start = 1'b1;
    lat = 0;
    done_cnt = 0;
    while (lat < 6) begin
      @(negedge clk);
      lat++;
      if (lat == 3) a = 4'd1;
      if (done) done_cnt++;
    end
    chk("hold_first_done", done, 1'b1);
    chk("hold_first_dif", dif, 4'd8);
    chk("hold_first_lt", a_lt_b, 1'b0);
    chk("hold_cmp_a_stable", cmp_a, 4'd12);
    @(negedge clk);
    chk("hold_idle_after_done", {busy, done}, 2'b00);
    @(negedge clk);
    start = 1'b0;
    chk("hold_second_accept_busy", busy, 1'b1);
    chk("hold_second_cmp_a", cmp_a, 4'd1);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_second_latency", lat, 6);
    chk("hold_second_dif", dif, 4'd3);
    chk("hold_second_lt", a_lt_b, 1'b1);
    chk("hold_single_done_first", done_cnt, 1);

    // reset in the 2nd SUB cycle aborts without a done strobe
    @(negedge clk);
    a = 4'd9; b = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_outs", {cmp_a, cmp_b, dif, a_lt_b, a_eq_b, err}, 15'd0);
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    run_op("a6_b10", 4'd6, 4'd10, 6, 4'd4, 1'b1, 1'b0, 1'b0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
